// File: rtl/lfsr12_pkg.sv
// Shared definitions for the 12-bit LFSR generator and sequence checker.
package lfsr12_pkg;

    localparam int unsigned LFSR_WIDTH = 12;
    localparam int unsigned CNT_WIDTH  = 16;

    typedef enum logic [1:0] {StIdle, StHunt, StLocked} chk_state_e;

    // Polynomial taps at bits 11, 10, 3, 0.
    function automatic logic [LFSR_WIDTH-1:0] lfsr12_next(input logic [LFSR_WIDTH-1:0] d);
        return {d[10:0], d[11] ^ d[10] ^ d[3] ^ d[0]};
    endfunction

endpackage

// File: rtl/lfsr12_seq_checker_if.sv
// Sample stream and status bundle between an LFSR source and the sequence checker.
interface lfsr12_seq_checker_if;
    import lfsr12_pkg::*;

    logic                  in_valid;
    logic [LFSR_WIDTH-1:0] in_data;
    logic                  clr;
    logic                  locked;
    logic                  err_pulse;
    logic [CNT_WIDTH-1:0]  err_count;
    logic [CNT_WIDTH-1:0]  good_count;
    logic                  stuck_zero;

    modport master (
        output in_valid, in_data, clr,
        input  locked, err_pulse, err_count, good_count, stuck_zero
    );

    modport slave (
        input  in_valid, in_data, clr,
        output locked, err_pulse, err_count, good_count, stuck_zero
    );

endinterface

// File: rtl/lfsr12_step.sv
// Combinational one-step advance of the 12-bit LFSR.
module lfsr12_step
    import lfsr12_pkg::*;
(
    input  logic [LFSR_WIDTH-1:0] cur,
    output logic [LFSR_WIDTH-1:0] nxt
);

    always_comb begin
        nxt = lfsr12_next(cur);
    end

endmodule

// File: rtl/lfsr12_seq_checker.sv
// Self-synchronising 12-bit LFSR sequence checker with lock/loss hysteresis and
// saturating error/good counters.
module lfsr12_seq_checker
    import lfsr12_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input logic                clk,
    input logic                rst,
    lfsr12_seq_checker_if.slave bus
);

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
    localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

    chk_state_e            state_q, state_d;
    logic [LFSR_WIDTH-1:0] prev_q, prev_d;
    logic [LFSR_WIDTH-1:0] pred;
    logic [3:0]            match_cnt_q, match_cnt_d;
    logic [3:0]            miss_cnt_q, miss_cnt_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0]  good_count_q, good_count_d;
    logic                  stuck_q, stuck_d;
    logic                  match;

    lfsr12_step u_step (
        .cur (prev_q),
        .nxt (pred)
    );

    // Zero is the LFSR lock-up word, so it never counts as a match.
    assign match = bus.in_valid && (bus.in_data == pred) && (bus.in_data != '0);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        good_count_d = good_count_q;
        stuck_d      = stuck_q;

        if (bus.in_valid) begin
            prev_d = bus.in_data;
            if (bus.in_data == '0) begin
                stuck_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    state_d     = StHunt;
                    match_cnt_d = '0;
                end
                StHunt: begin
                    if (!match) begin
                        match_cnt_d = '0;
                    end else if (match_cnt_q + 4'd1 == LockCnt) begin
                        state_d     = StLocked;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 4'd1;
                    end
                end
                StLocked: begin
                    if (match) begin
                        miss_cnt_d = '0;
                        if (!bus.clr && good_count_q != '1) begin
                            good_count_d = good_count_q + 16'd1;
                        end
                    end else begin
                        if (!bus.clr) begin
                            err_pulse_d = 1'b1;
                            if (err_count_q != '1) begin
                                err_count_d = err_count_q + 16'd1;
                            end
                        end
                        if (miss_cnt_q + 4'd1 == LossCnt) begin
                            state_d     = StHunt;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Clear only touches the reported statistics; lock tracking carries on.
        if (bus.clr) begin
            err_count_d  = '0;
            good_count_d = '0;
            stuck_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            prev_q       <= '0;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            good_count_q <= '0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            good_count_q <= good_count_d;
            stuck_q      <= stuck_d;
        end
    end

    assign bus.locked     = (state_q == StLocked);
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.good_count = good_count_q;
    assign bus.stuck_zero = stuck_q;

endmodule

// File: tb/tb_lfsr12_seq_checker.sv
// Bench for lfsr12_seq_checker: directed scenarios plus random stream against a reference model.
module tb_lfsr12_seq_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [11:0] cur;

    // Reference model: sample-level rules, phase 0 = idle, 1 = hunting, 2 = locked.
    int          m_phase, m_run, m_miss, m_err, m_good;
    logic [11:0] m_prev;
    logic        m_stuck, m_pulse;

    always #5 clk = ~clk;

    lfsr12_seq_checker_if u_if ();
    lfsr12_seq_checker_if u_if_sat ();

    lfsr12_seq_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    lfsr12_seq_checker #(.LOCK_COUNT(1), .LOSS_COUNT(15)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (u_if_sat.slave)
    );

    function automatic logic [11:0] ref_next(input logic [11:0] d);
        return (d << 1) | {11'd0, ^(d & 12'hC09)};
    endfunction

    task automatic model_step(input logic v, input logic [11:0] d, input logic c, input logic r);
        bit hit;
        m_pulse = 1'b0;
        if (r) begin
            m_phase = 0; m_prev = '0; m_run = 0; m_miss = 0;
            m_err = 0; m_good = 0; m_stuck = 1'b0;
            return;
        end
        if (v) begin
            hit = (d == ref_next(m_prev)) && (d != 12'd0);
            if (d == 12'd0) m_stuck = 1'b1;
            if (m_phase == 0) begin
                m_phase = 1; m_run = 0;
            end else if (m_phase == 1) begin
                m_run = hit ? m_run + 1 : 0;
                if (m_run == LOCK_N) begin m_phase = 2; m_miss = 0; m_run = 0; end
            end else if (hit) begin
                m_miss = 0;
                if (!c && m_good < 65535) m_good++;
            end else begin
                m_miss++;
                if (!c) begin
                    m_pulse = 1'b1;
                    if (m_err < 65535) m_err++;
                end
                if (m_miss == LOSS_N) begin m_phase = 1; m_run = 0; m_miss = 0; end
            end
            m_prev = d;
        end
        if (c) begin m_err = 0; m_good = 0; m_stuck = 1'b0; end
    endtask

    // One clock of stimulus on the main DUT; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic v, input logic [11:0] d, input logic c, input logic r);
        rst = r; u_if.in_valid = v; u_if.in_data = d; u_if.clr = c;
        @(posedge clk);
        #1;
        model_step(v, d, c, r);
    endtask

    task automatic send_next();
        cur = ref_next(cur);
        cyc(1'b1, cur, 1'b0, 1'b0);
    endtask

    task automatic bring_up();
        cyc(1'b0, 12'd0, 1'b0, 1'b1);
        cur = 12'h001;
        cyc(1'b1, cur, 1'b0, 1'b0);
        repeat (LOCK_N) send_next();
    endtask

    task automatic test_reset();
        cyc(1'b1, 12'h123, 1'b1, 1'b1);
        n_checks++; if (u_if.locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got=%0h exp=0", u_if.locked); end
        n_checks++; if (u_if.err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got=%0h exp=0", u_if.err_pulse); end
        n_checks++; if (u_if.err_count !== 16'd0) begin n_fail++; $display("FAIL rst_err got=%0h exp=0", u_if.err_count); end
        n_checks++; if (u_if.good_count !== 16'd0) begin n_fail++; $display("FAIL rst_good got=%0h exp=0", u_if.good_count); end
        n_checks++; if (u_if.stuck_zero !== 1'b0) begin n_fail++; $display("FAIL rst_stuck got=%0h exp=0", u_if.stuck_zero); end
    endtask

    task automatic test_lock_sequence();
        logic [11:0] seq [6] = '{12'h001, 12'h003, 12'h007, 12'h00F, 12'h01E, 12'h03D};
        cyc(1'b0, 12'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, seq[i], 1'b0, 1'b0);
            n_checks++;
            if (u_if.locked !== (i >= 4)) begin
                n_fail++; $display("FAIL lock_seq[%0d] locked got=%0h exp=%0h", i, u_if.locked, i >= 4);
            end
        end
        cur = 12'h03D;
        n_checks++; if (u_if.good_count !== 16'd1) begin n_fail++; $display("FAIL lock_good got=%0h exp=1", u_if.good_count); end
        n_checks++; if (u_if.err_count !== 16'd0) begin n_fail++; $display("FAIL lock_err got=%0h exp=0", u_if.err_count); end
    endtask

    task automatic test_single_error();
        cyc(1'b1, 12'h555, 1'b0, 1'b0);
        n_checks++; if (u_if.err_pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse got=%0h exp=1", u_if.err_pulse); end
        n_checks++; if (u_if.err_count !== 16'd1) begin n_fail++; $display("FAIL single_err got=%0h exp=1", u_if.err_count); end
        cur = 12'h555;
        send_next();
        n_checks++; if (u_if.err_pulse !== 1'b0) begin n_fail++; $display("FAIL single_pulse_low got=%0h exp=0", u_if.err_pulse); end
        repeat (3) send_next();
        n_checks++; if (u_if.locked !== 1'b1) begin n_fail++; $display("FAIL single_locked got=%0h exp=1", u_if.locked); end
        n_checks++; if (u_if.good_count !== 16'd5) begin n_fail++; $display("FAIL single_good got=%0h exp=5", u_if.good_count); end
        n_checks++; if (u_if.err_count !== 16'd1) begin n_fail++; $display("FAIL single_err_hold got=%0h exp=1", u_if.err_count); end
    endtask

    task automatic test_loss_relock();
        bring_up();
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 12'h0AA, 1'b0, 1'b0);
            n_checks++;
            if (u_if.err_count !== 16'(i) || u_if.locked !== (i < 3)) begin
                n_fail++; $display("FAIL loss[%0d] err=%0h locked=%0h exp err=%0h locked=%0h",
                                   i, u_if.err_count, u_if.locked, i, i < 3);
            end
        end
        cur = 12'h0AA;
        for (int i = 1; i <= 4; i++) begin
            send_next();
            n_checks++;
            if (u_if.locked !== (i == 4)) begin
                n_fail++; $display("FAIL relock[%0d] locked got=%0h exp=%0h", i, u_if.locked, i == 4);
            end
        end
    endtask

    task automatic test_zero_clr();
        bring_up();
        cyc(1'b1, 12'h000, 1'b0, 1'b0);
        n_checks++; if (u_if.stuck_zero !== 1'b1) begin n_fail++; $display("FAIL zero_stuck got=%0h exp=1", u_if.stuck_zero); end
        n_checks++; if (u_if.err_count !== 16'd1) begin n_fail++; $display("FAIL zero_err got=%0h exp=1", u_if.err_count); end
        cyc(1'b0, 12'hABC, 1'b1, 1'b0);
        n_checks++;
        if (u_if.stuck_zero !== 1'b0 || u_if.err_count !== 16'd0 || u_if.good_count !== 16'd0 || u_if.locked !== 1'b1) begin
            n_fail++; $display("FAIL clr stuck=%0h err=%0h good=%0h locked=%0h exp 0/0/0/1",
                               u_if.stuck_zero, u_if.err_count, u_if.good_count, u_if.locked);
        end
        // Mismatch accompanied by clr must not count or pulse.
        cyc(1'b1, 12'h001, 1'b1, 1'b0);
        n_checks++;
        if (u_if.err_count !== 16'd0 || u_if.err_pulse !== 1'b0) begin
            n_fail++; $display("FAIL clr_sample err=%0h pulse=%0h exp 0/0", u_if.err_count, u_if.err_pulse);
        end
        cur = 12'h001;
        send_next();
        n_checks++;
        if (u_if.good_count !== 16'd1 || u_if.locked !== 1'b1) begin
            n_fail++; $display("FAIL clr_resume good=%0h locked=%0h exp 1/1", u_if.good_count, u_if.locked);
        end
    endtask

    task automatic test_gaps();
        bring_up();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 12'($urandom), 1'b0, 1'b0);
            send_next();
        end
        n_checks++; if (u_if.good_count !== 16'd6) begin n_fail++; $display("FAIL gaps_good got=%0h exp=6", u_if.good_count); end
        cyc(1'b1, 12'h555, 1'b0, 1'b0);
        cyc(1'b0, 12'h000, 1'b0, 1'b0);
        n_checks++;
        if (u_if.err_pulse !== 1'b0 || u_if.err_count !== 16'd1 || u_if.locked !== 1'b1 || u_if.stuck_zero !== 1'b0) begin
            n_fail++; $display("FAIL gap_after_err pulse=%0h err=%0h locked=%0h stuck=%0h exp 0/1/1/0",
                               u_if.err_pulse, u_if.err_count, u_if.locked, u_if.stuck_zero);
        end
    endtask

    task automatic test_reset_midstream();
        bring_up();
        cyc(1'b1, ref_next(cur), 1'b1, 1'b1);
        n_checks++;
        if (u_if.locked !== 1'b0 || u_if.good_count !== 16'd0 || u_if.err_count !== 16'd0) begin
            n_fail++; $display("FAIL midrst locked=%0h good=%0h err=%0h exp 0/0/0",
                               u_if.locked, u_if.good_count, u_if.err_count);
        end
        cur = 12'h7A3;
        cyc(1'b1, cur, 1'b0, 1'b0);
        for (int i = 1; i <= LOCK_N; i++) begin
            send_next();
            n_checks++;
            if (u_if.locked !== (i == LOCK_N)) begin
                n_fail++; $display("FAIL midrst_relock[%0d] got=%0h exp=%0h", i, u_if.locked, i == LOCK_N);
            end
        end
    endtask

    task automatic test_random();
        int          p;
        logic        v, c, r;
        logic [11:0] d;
        cyc(1'b0, 12'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 99) < 85);
            c = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 999) < 3);
            p = $urandom_range(0, 99);
            d = (p < 82) ? ref_next(m_prev) : (p < 86) ? 12'd0 : 12'($urandom);
            cyc(v, d, c, r);
            n_checks++;
            if (u_if.locked !== (m_phase == 2) || u_if.err_pulse !== m_pulse ||
                u_if.err_count !== 16'(m_err) || u_if.good_count !== 16'(m_good) ||
                u_if.stuck_zero !== m_stuck) begin
                n_fail++;
                $display("FAIL rand[%0d] got l=%0h p=%0h e=%0h g=%0h s=%0h exp l=%0h p=%0h e=%0h g=%0h s=%0h",
                         i, u_if.locked, u_if.err_pulse, u_if.err_count, u_if.good_count, u_if.stuck_zero,
                         m_phase == 2, m_pulse, 16'(m_err), 16'(m_good), m_stuck);
            end
        end
    endtask

    task automatic sat_send(input logic [11:0] d);
        u_if_sat.in_valid = 1'b1; u_if_sat.in_data = d;
        @(posedge clk);
        #1;
    endtask

    // LOSS_COUNT=15 lets 14 errors accrue per correct sample without dropping lock.
    task automatic test_saturation();
        int n_err = 0;
        int n_good = 0;
        u_if.in_valid = 1'b0; u_if.clr = 1'b0;
        sat_send(12'h001);
        sat_send(12'h003);
        while (n_err < 65535) begin
            for (int k = 0; k < 14 && n_err < 65535; k++) begin
                sat_send(12'h0AA);
                n_err++;
            end
            sat_send(ref_next(12'h0AA));
            n_good++;
        end
        n_checks++; if (u_if_sat.err_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_pre err got=%0h exp=ffff", u_if_sat.err_count); end
        n_checks++; if (u_if_sat.good_count !== 16'(n_good)) begin n_fail++; $display("FAIL sat_good got=%0h exp=%0h", u_if_sat.good_count, 16'(n_good)); end
        sat_send(12'h0AA);
        n_checks++;
        if (u_if_sat.err_count !== 16'hFFFF || u_if_sat.err_pulse !== 1'b1 || u_if_sat.locked !== 1'b1) begin
            n_fail++; $display("FAIL sat err=%0h pulse=%0h locked=%0h exp ffff/1/1",
                               u_if_sat.err_count, u_if_sat.err_pulse, u_if_sat.locked);
        end
        u_if_sat.in_valid = 1'b0;
    endtask

    initial begin
        u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.clr = 1'b0;
        u_if_sat.in_valid = 1'b0; u_if_sat.in_data = '0; u_if_sat.clr = 1'b0;
        model_step(1'b0, 12'd0, 1'b0, 1'b1);
        test_reset();
        test_lock_sequence();
        test_single_error();
        test_loss_relock();
        test_zero_clr();
        test_gaps();
        test_reset_midstream();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr12_seq_checker.md
LFSR12_SEQ_CHECKER -- requirements
Module: lfsr12_seq_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive matching samples needed to enter LOCKED (range 1..15).
REQ-002 Parameter LOSS_COUNT, default 3: consecutive mismatching samples in LOCKED that force return to HUNT (range 1..15).
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: in_data is a sample this cycle.
REQ-006 Port in_data, input, 12: received 12-bit LFSR word.
REQ-007 Port clr, input, 1: synchronous clear of counters and sticky flags; does not change state.
REQ-008 Port locked, output, 1: high while state is LOCKED.
REQ-009 Port err_pulse, output, 1: one-cycle pulse per counted error.
REQ-010 Port err_count, output, 16: saturating count of mismatches while LOCKED.
REQ-011 Port good_count, output, 16: saturating count of matching samples while LOCKED.
REQ-012 Port stuck_zero, output, 1: sticky; set by any accepted all-zero sample.

Function
REQ-013 Next-word function SHALL be next(d) = {d[10:0], d[11]^d[10]^d[3]^d[0]}.
REQ-014 Checker SHALL keep prev (last accepted sample); prediction = next(prev); match = in_valid and in_data == prediction and in_data != 0.
REQ-015 Every accepted sample (in_valid=1) SHALL overwrite prev, giving self-synchronisation after any discontinuity (e.g. generator reseed).
REQ-016 Cycles with in_valid=0 SHALL change no state, counter, or output except err_pulse, which goes low.
REQ-017 States SHALL be IDLE, HUNT, LOCKED.
REQ-018 IDLE: first accepted sample loads prev and moves to HUNT with match_cnt=0; no compare.
REQ-019 HUNT: match increments match_cnt; on reaching LOCK_COUNT, move to LOCKED, miss_cnt=0; mismatch clears match_cnt; no errors counted in HUNT.
REQ-020 LOCKED: match clears miss_cnt and increments good_count; mismatch increments err_count, pulses err_pulse, increments miss_cnt; on reaching LOSS_COUNT, move to HUNT with match_cnt=0.
REQ-021 An all-zero sample SHALL always be a mismatch, even when predicted zero.
REQ-022 All outputs SHALL be registered; locked, err_pulse and counters reflect a sample on the cycle after it is accepted.
REQ-023 err_count and good_count SHALL saturate at 16'hFFFF; err_pulse still fires at saturation.
REQ-024 clr together with a sample SHALL win: counters and stuck_zero go to 0 and that sample is not counted; FSM and prev still update normally.
REQ-025 Once LOCKED, isolated mismatches fewer than LOSS_COUNT SHALL NOT deassert locked.

Reset
REQ-026 rst SHALL force IDLE, prev=12'h000, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0, good_count=0, stuck_zero=0.
REQ-027 rst SHALL override in_valid and clr in the same cycle; reset mid-stream discards lock and restarts from IDLE.

Structure
REQ-028 Package lfsr12_pkg SHALL hold LFSR_WIDTH=12, the state enum type, and the next-word function, shared with the generator.
REQ-029 One sub-module lfsr12_step (combinational 12-bit next-word) SHALL be instantiated for the prediction.

Verification
REQ-030 Reset, then stream 001,003,007,00F,01E,03D (LOCK_COUNT=4) -> locked=1 the cycle after 01E; good_count=1 after 03D; err_count=0.
REQ-031 Locked, inject 555 instead of expected value, then continue correctly from next(555) -> err_pulse once, err_count=1, locked stays 1.
REQ-032 Locked, three consecutive wrong samples 0AA,0AA,0AA -> err_count=3, locked=0 after third; the correct stream relocks after 4 matches.
REQ-033 Locked, sample 000 -> stuck_zero=1, err_count+1; clr -> stuck_zero=0, counters 0, locked unchanged.
REQ-034 Preload err_count to FFFF via forced mismatches, one more error -> err_count=FFFF, err_pulse=1.
REQ-035 Assert rst while locked with in_valid=1 -> next cycle locked=0, counts 0, state IDLE; in_valid gaps mid-stream do not break lock.
